// File: rtl/i2c_regbank_arbiter_pkg.sv
// Shared encodings for the I2C register-bank arbiter: FSM states, op owners
// and default widths.
package i2c_regbank_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] S_ARB  = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OWN_I2CW = 2'd0;
    localparam logic [1:0] OWN_I2CR = 2'd1;
    localparam logic [1:0] OWN_L0   = 2'd2;
    localparam logic [1:0] OWN_L1   = 2'd3;

endpackage

// File: rtl/regbank_rr2.sv
// Two-way round-robin grant. The pointer names the preferred port and moves to
// the other port after every local grant.
module regbank_rr2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_ptr;

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11)
            o_grant = r_ptr ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= 1'b0;
        else if (i_advance && (o_grant != 2'b00))
            r_ptr <= o_grant[0];
    end

endmodule

// File: rtl/i2c_regbank_arbiter.sv
// Shares one single-port 256x8 register RAM between the I2C slave (buffered
// writes, prefetched reads) and two round-robin local req/ack ports.
module i2c_regbank_arbiter
    import i2c_regbank_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_din,
    input  logic              i2c_w,
    output logic [DATA_W-1:0] i2c_dout,
    input  logic              loc0_req,
    input  logic              loc0_we,
    input  logic [ADDR_W-1:0] loc0_addr,
    input  logic [DATA_W-1:0] loc0_wdata,
    output logic              loc0_ack,
    output logic [DATA_W-1:0] loc0_rdata,
    input  logic              loc1_req,
    input  logic              loc1_we,
    input  logic [ADDR_W-1:0] loc1_addr,
    input  logic [DATA_W-1:0] loc1_wdata,
    output logic              loc1_ack,
    output logic [DATA_W-1:0] loc1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              err_ovf
);

    logic [1:0]        r_state;
    logic [1:0]        r_owner;
    logic              r_op_we;
    logic [ADDR_W-1:0] r_op_addr;
    logic [DATA_W-1:0] r_op_wdata;

    logic              r_i2c_w_d;
    logic              r_wpend;
    logic [ADDR_W-1:0] r_wbuf_addr;
    logic [DATA_W-1:0] r_wbuf_data;
    logic              r_err_ovf;

    logic [ADDR_W-1:0] r_faddr;
    logic              r_fvalid;
    logic [DATA_W-1:0] r_i2c_dout;
    logic [DATA_W-1:0] r_loc0_rdata;
    logic [DATA_W-1:0] r_loc1_rdata;

    logic       w_cap;
    logic       w_need_pf;
    logic       w_arb;
    logic       w_exec;
    logic       w_done;
    logic       w_take_w;
    logic       w_loc_ok;
    logic [1:0] w_gnt;

    assign w_cap     = i2c_w & ~r_i2c_w_d;
    assign w_need_pf = ~r_fvalid | (i2c_addr != r_faddr);
    assign w_arb     = (r_state == S_ARB);
    assign w_exec    = (r_state == S_EXEC);
    assign w_done    = (r_state == S_DONE);
    assign w_take_w  = w_arb & r_wpend;
    assign w_loc_ok  = w_arb & ~r_wpend & ~w_need_pf;

    regbank_rr2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .i_req     ({loc1_req, loc0_req}),
        .i_advance (w_loc_ok),
        .o_grant   (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_ARB;
            r_owner    <= OWN_I2CW;
            r_op_we    <= 1'b0;
            r_op_addr  <= '0;
            r_op_wdata <= '0;
        end else begin
            case (r_state)
                S_ARB: begin
                    if (r_wpend) begin
                        r_owner    <= OWN_I2CW;
                        r_op_we    <= 1'b1;
                        r_op_addr  <= r_wbuf_addr;
                        r_op_wdata <= r_wbuf_data;
                        r_state    <= S_EXEC;
                    end else if (w_need_pf) begin
                        r_owner    <= OWN_I2CR;
                        r_op_we    <= 1'b0;
                        r_op_addr  <= i2c_addr;
                        r_op_wdata <= '0;
                        r_state    <= S_EXEC;
                    end else if (w_gnt[0]) begin
                        r_owner    <= OWN_L0;
                        r_op_we    <= loc0_we;
                        r_op_addr  <= loc0_addr;
                        r_op_wdata <= loc0_wdata;
                        r_state    <= S_EXEC;
                    end else if (w_gnt[1]) begin
                        r_owner    <= OWN_L1;
                        r_op_we    <= loc1_we;
                        r_op_addr  <= loc1_addr;
                        r_op_wdata <= loc1_wdata;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC:  r_state <= S_DONE;
                default: r_state <= S_ARB;
            endcase
        end
    end

    // A capture coinciding with the buffer being drained is not a loss.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i2c_w_d   <= 1'b0;
            r_wpend     <= 1'b0;
            r_wbuf_addr <= '0;
            r_wbuf_data <= '0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_i2c_w_d <= i2c_w;
            if (w_cap) begin
                r_wbuf_addr <= i2c_addr;
                r_wbuf_data <= i2c_din;
                r_wpend     <= 1'b1;
                if (r_wpend && !w_take_w)
                    r_err_ovf <= 1'b1;
            end else if (w_take_w) begin
                r_wpend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_faddr      <= '0;
            r_fvalid     <= 1'b0;
            r_i2c_dout   <= '0;
            r_loc0_rdata <= '0;
            r_loc1_rdata <= '0;
        end else if (w_done) begin
            if (r_op_we && (r_op_addr == r_faddr))
                r_fvalid <= 1'b0;
            case (r_owner)
                OWN_I2CR: begin
                    r_i2c_dout <= ram_rdata;
                    r_faddr    <= r_op_addr;
                    r_fvalid   <= 1'b1;
                end
                OWN_L0:  if (!r_op_we) r_loc0_rdata <= ram_rdata;
                OWN_L1:  if (!r_op_we) r_loc1_rdata <= ram_rdata;
                default: ;
            endcase
        end
    end

    assign ram_en    = w_exec;
    assign ram_we    = w_exec & r_op_we;
    assign ram_addr  = w_exec ? r_op_addr  : '0;
    assign ram_wdata = w_exec ? r_op_wdata : '0;

    assign loc0_ack = w_done & (r_owner == OWN_L0);
    assign loc1_ack = w_done & (r_owner == OWN_L1);

    // Read data bypasses the holding register so it is valid in the ack cycle.
    assign loc0_rdata = (loc0_ack & ~r_op_we) ? ram_rdata : r_loc0_rdata;
    assign loc1_rdata = (loc1_ack & ~r_op_we) ? ram_rdata : r_loc1_rdata;

    assign i2c_dout = r_i2c_dout;
    assign err_ovf  = r_err_ovf;

endmodule

// File: tb/tb_i2c_regbank_arbiter.sv
// Bench for i2c_regbank_arbiter: RAM model, directed scenarios, then random
// local/I2C traffic checked against a golden register-file model.
module tb_i2c_regbank_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] i2c_addr, i2c_din, i2c_dout;
    logic       i2c_w;
    logic       loc0_req, loc0_we, loc0_ack;
    logic [7:0] loc0_addr, loc0_wdata, loc0_rdata;
    logic       loc1_req, loc1_we, loc1_ack;
    logic [7:0] loc1_addr, loc1_wdata, loc1_rdata;
    logic       ram_en, ram_we, err_ovf;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;

    i2c_regbank_arbiter dut (
        .clk(clk), .reset(reset),
        .i2c_addr(i2c_addr), .i2c_din(i2c_din), .i2c_w(i2c_w), .i2c_dout(i2c_dout),
        .loc0_req(loc0_req), .loc0_we(loc0_we), .loc0_addr(loc0_addr),
        .loc0_wdata(loc0_wdata), .loc0_ack(loc0_ack), .loc0_rdata(loc0_rdata),
        .loc1_req(loc1_req), .loc1_we(loc1_we), .loc1_addr(loc1_addr),
        .loc1_wdata(loc1_wdata), .loc1_ack(loc1_ack), .loc1_rdata(loc1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seed_val(input int i);
        if (i == 'h10) return 8'hA5;
        if (i == 5)    return 8'h11;
        return 8'(i * 29 + 7) ^ 8'(i >> 2);
    endfunction

    // Synchronous RAM: contents seeded on the first edge, read data one cycle later.
    logic [7:0] mem [256];
    bit         mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed_val(i);
            mem_ready <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    int   ack0_cnt = 0, ack1_cnt = 0, dbl_cnt = 0, wr20_cnt = 0, last_op20 = 0;
    logic prev0 = 1'b0, prev1 = 1'b0;
    always @(posedge clk) begin
        if (loc0_ack) ack0_cnt <= ack0_cnt + 1;
        if (loc1_ack) ack1_cnt <= ack1_cnt + 1;
        if ((loc0_ack && prev0) || (loc1_ack && prev1)) dbl_cnt <= dbl_cnt + 1;
        prev0 <= loc0_ack;
        prev1 <= loc1_ack;
        if (ram_en && ram_addr == 8'h20) begin
            if (ram_we) begin wr20_cnt <= wr20_cnt + 1; last_op20 <= 1; end
            else last_op20 <= 2;
        end
    end

    int         nvec = 0, nfail = 0;
    logic [7:0] gold [256];
    logic       e0_we, e1_we;
    logic [7:0] e0_addr, e0_data, e1_addr, e1_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dout(input logic [7:0] exp, input int maxc, input string tag);
        int n = 0;
        while (i2c_dout !== exp && n < maxc) begin step(); n++; end
        check(tag, i2c_dout, exp);
    endtask

    task automatic wait_ack(input int port, input int maxc, input string tag);
        int n = 0;
        while (((port == 0) ? loc0_ack : loc1_ack) !== 1'b1 && n < maxc) begin step(); n++; end
        check(tag, (port == 0) ? loc0_ack : loc1_ack, 1);
    endtask

    initial begin
        int  n, nack, a0, w0, w1;
        bit  exp_who, p0, p1;
        reset = 1'b1; i2c_addr = 8'h10; i2c_din = '0; i2c_w = 1'b0;
        loc0_req = 0; loc0_we = 0; loc0_addr = '0; loc0_wdata = '0;
        loc1_req = 0; loc1_we = 0; loc1_addr = '0; loc1_wdata = '0;
        for (int i = 0; i < 256; i++) gold[i] = seed_val(i);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", i2c_dout, 0);
        check("rst_ack0", loc0_ack, 0);
        check("rst_ack1", loc1_ack, 0);
        check("rst_rdata0", loc0_rdata, 0);
        check("rst_rdata1", loc1_rdata, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_err", err_ovf, 0);
        reset = 1'b0;

        // Forced prefetch after reset
        step();
        check("t1_pf_en", ram_en, 1);
        check("t1_pf_addr", ram_addr, 8'h10);
        check("t1_pf_we", ram_we, 0);
        step(); step();
        check("t1_dout", i2c_dout, 8'hA5);
        check("t1_noack", ack0_cnt + ack1_cnt, 0);

        // I2C write then read-back of the same register
        a0 = wr20_cnt;
        i2c_addr = 8'h20; i2c_din = 8'h3C; i2c_w = 1'b1;
        gold[8'h20] = 8'h3C;
        wait_dout(8'h3C, 15, "t2_dout");
        i2c_w = 1'b0;
        check("t2_wr_once", wr20_cnt - a0, 1);
        check("t2_rd_last", last_op20, 2);
        check("t2_err", err_ovf, 0);

        // Both local ports reading: strict alternation starting at loc0
        loc0_we = 0; loc0_addr = 8'h01; loc1_we = 0; loc1_addr = 8'h02;
        loc0_req = 1; loc1_req = 1;
        nack = 0; n = 0; exp_who = 1'b0;
        while (nack < 6 && n < 40) begin
            step(); n++;
            if (loc0_ack || loc1_ack) begin
                check("t3_order", {loc1_ack, loc0_ack}, exp_who ? 2'b10 : 2'b01);
                if (loc0_ack) check("t3_rd0", loc0_rdata, gold[1]);
                else begin
                    check("t3_rd1", loc1_rdata, gold[2]);
                    check("t3_hold0", loc0_rdata, gold[1]);
                end
                exp_who = ~exp_who;
                nack++;
            end
        end
        loc0_req = 0; loc1_req = 0;
        check("t3_count", nack, 6);
        check("t3_dbl", dbl_cnt, 0);

        // Minimum latency: req in S_ARB cycle T, ack in T+2
        step();
        loc0_req = 1; loc0_addr = 8'h02;
        step();
        check("lat_t1", loc0_ack, 0);
        step();
        check("lat_t2", loc0_ack, 1);
        check("lat_rd", loc0_rdata, gold[2]);
        loc0_req = 0;
        step();

        // Local write to the prefetched address forces a refetch
        i2c_addr = 8'h05;
        wait_dout(8'h11, 15, "t4_pf");
        loc1_we = 1; loc1_addr = 8'h05; loc1_wdata = 8'h77; loc1_req = 1;
        wait_ack(1, 15, "t4_ack");
        check("t4_old", i2c_dout, 8'h11);
        loc1_req = 0; loc1_we = 0;
        gold[8'h05] = 8'h77;
        wait_dout(8'h77, 10, "t4_new");

        // Two captures inside one busy operation -> overflow
        loc0_we = 0; loc0_addr = 8'h03; loc0_req = 1;
        n = 0;
        while (!ram_en && n < 10) begin step(); n++; end
        check("t5_busy", ram_en, 1);
        step(); step();
        i2c_addr = 8'h30; i2c_din = 8'h01; i2c_w = 1'b1;
        step();
        i2c_w = 1'b0;
        step();
        i2c_addr = 8'h31; i2c_din = 8'h02; i2c_w = 1'b1;
        step();
        check("t5_ovf", err_ovf, 1);
        gold[8'h31] = 8'h02;
        wait_ack(0, 20, "t5_ack0");
        loc0_req = 0;
        wait_dout(8'h02, 20, "t5_dout");
        i2c_w = 1'b0;
        repeat (10) step();
        check("t5_sticky", err_ovf, 1);
        check("t5_mem30", mem[8'h30], gold[8'h30]);
        check("t5_mem31", mem[8'h31], 8'h02);

        // Reset during S_EXEC of a local read
        a0 = ack0_cnt;
        loc0_we = 0; loc0_addr = 8'h01; loc0_req = 1;
        step();
        check("t6_exec", ram_en, 1);
        reset = 1'b1; loc0_req = 0;
        step();
        check("t6_ack0", loc0_ack, 0);
        check("t6_dout", i2c_dout, 0);
        check("t6_err", err_ovf, 0);
        check("t6_rdata0", loc0_rdata, 0);
        check("t6_rdata1", loc1_rdata, 0);
        check("t6_ram_en", ram_en, 0);
        reset = 1'b0;
        step();
        check("t6_pf_en", ram_en, 1);
        check("t6_pf_addr", ram_addr, 8'h31);
        check("t6_pf_we", ram_we, 0);
        step(); step();
        check("t6_pf_dout", i2c_dout, 8'h02);
        check("t6_no_ack", ack0_cnt - a0, 0);

        // Random traffic: disjoint address ranges per source, golden register file
        p0 = 0; p1 = 0; w0 = 0; w1 = 0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            step();
            if (loc0_ack) begin
                check("r0_spur", p0, 1);
                if (e0_we) gold[e0_addr] = e0_data;
                else       check("r0_rd", loc0_rdata, gold[e0_addr]);
                p0 = 0;
            end
            if (loc1_ack) begin
                check("r1_spur", p1, 1);
                if (e1_we) gold[e1_addr] = e1_data;
                else       check("r1_rd", loc1_rdata, gold[e1_addr]);
                p1 = 0;
            end
            if (p0) begin
                w0++;
                if (w0 > 30) begin check("r0_timeout", w0, 30); p0 = 0; loc0_req = 0; end
            end
            if (p1) begin
                w1++;
                if (w1 > 30) begin check("r1_timeout", w1, 30); p1 = 0; loc1_req = 0; end
            end
            if (!p0) begin
                if (cyc < 1550 && $urandom_range(0, 2) != 0) begin
                    e0_we = 1'($urandom_range(0, 1)); e0_addr = 8'h40 + 8'($urandom_range(0, 63));
                    e0_data = 8'($urandom);
                    loc0_we = e0_we; loc0_addr = e0_addr; loc0_wdata = e0_data;
                    loc0_req = 1; p0 = 1; w0 = 0;
                end else loc0_req = 0;
            end
            if (!p1) begin
                if (cyc < 1550 && $urandom_range(0, 2) != 0) begin
                    e1_we = 1'($urandom_range(0, 1)); e1_addr = 8'h80 + 8'($urandom_range(0, 63));
                    e1_data = 8'($urandom);
                    loc1_we = e1_we; loc1_addr = e1_addr; loc1_wdata = e1_data;
                    loc1_req = 1; p1 = 1; w1 = 0;
                end else loc1_req = 0;
            end
            case (cyc % 16)
                0: begin
                    i2c_addr = 8'hC0 + 8'($urandom_range(0, 63));
                    i2c_din = 8'($urandom); i2c_w = 1'b1;
                    gold[i2c_addr] = i2c_din;
                end
                4:  i2c_w = 1'b0;
                15: check("ri2c_dout", i2c_dout, gold[i2c_addr]);
                default: ;
            endcase
        end
        check("r_drain0", p0, 0);
        check("r_drain1", p1, 0);

        n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) n++;
        check("final_mem", n, 0);
        check("final_dbl", dbl_cnt, 0);
        check("final_err", err_ovf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
